// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and defaults for the L2 two-master arbiter
package l2_arb_pkg;

   typedef enum logic {
      MST_SOC = 1'b0,
      MST_DBG = 1'b1
   } mst_id_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hBADA_CCE5;

   typedef struct packed {
      logic    valid;
      mst_id_e id;
      logic    err;
   } rsp_t;

endpackage

// File: rtl/l2_rr_arb2.sv
// rtl/l2_rr_arb2.sv - 2-way round-robin grant with bounded burst hold
module l2_rr_arb2 import l2_arb_pkg::*; #(
   parameter int MAX_BURST = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic soc_req_i,
   input  logic dbg_req_i,
   output logic soc_gnt_o,
   output logic dbg_gnt_o
);

   localparam int              CNT_W   = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

   mst_id_e          owner_q, owner_d;
   logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic             burst_live_q, burst_live_d;
   mst_id_e          winner;
   logic             any_req;

   // burst_live_q stays clear until the first grant after reset, so the reset
   // owner holds no burst and a contended first cycle goes to the other master.
   always_comb begin
      any_req = soc_req_i | dbg_req_i;
      winner  = MST_SOC;
      if (dbg_req_i && !soc_req_i) begin
         winner = MST_DBG;
      end else if (dbg_req_i && soc_req_i) begin
         if (burst_live_q && (burst_cnt_q < CNT_MAX)) begin
            winner = owner_q;
         end else begin
            winner = (owner_q == MST_DBG) ? MST_SOC : MST_DBG;
         end
      end

      owner_d      = owner_q;
      burst_cnt_d  = burst_cnt_q;
      burst_live_d = burst_live_q;
      if (!any_req) begin
         burst_cnt_d = '0;
      end else begin
         burst_live_d = 1'b1;
         if (winner == owner_q) begin
            if (burst_cnt_q != CNT_MAX) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
            end
         end else begin
            owner_d     = winner;
            burst_cnt_d = '0;
         end
      end

      dbg_gnt_o = any_req && !rst_i && (winner == MST_DBG);
      soc_gnt_o = any_req && !rst_i && (winner == MST_SOC);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_q      <= MST_SOC;
         burst_cnt_q  <= '0;
         burst_live_q <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         burst_cnt_q  <= burst_cnt_d;
         burst_live_q <= burst_live_d;
      end
   end

endmodule

// File: rtl/l2_port_arbiter.sv
// rtl/l2_port_arbiter.sv - debug/SoC arbiter in front of the single-port L2 SRAM
module l2_port_arbiter import l2_arb_pkg::*; #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [31:0]           L2_BASE    = 32'h0000_0000,
   parameter logic [31:0]           L2_SIZE    = 32'h0001_0000,
   parameter int                    MAX_BURST  = 4,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    dbg_req_i,
   input  logic [ADDR_WIDTH-1:0]   dbg_addr_i,
   input  logic                    dbg_we_i,
   input  logic [DATA_WIDTH/8-1:0] dbg_be_i,
   input  logic [DATA_WIDTH-1:0]   dbg_wdata_i,
   output logic                    dbg_gnt_o,
   output logic                    dbg_rvalid_o,
   output logic [DATA_WIDTH-1:0]   dbg_rdata_o,
   output logic                    dbg_err_o,
   input  logic                    soc_req_i,
   input  logic [ADDR_WIDTH-1:0]   soc_addr_i,
   input  logic                    soc_we_i,
   input  logic [DATA_WIDTH/8-1:0] soc_be_i,
   input  logic [DATA_WIDTH-1:0]   soc_wdata_i,
   output logic                    soc_gnt_o,
   output logic                    soc_rvalid_o,
   output logic [DATA_WIDTH-1:0]   soc_rdata_o,
   output logic                    soc_err_o,
   output logic                    mem_req_o,
   output logic                    mem_we_o,
   output logic [ADDR_WIDTH-3:0]   mem_addr_o,
   output logic [DATA_WIDTH/8-1:0] mem_be_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);

   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(L2_BASE);
   localparam logic [ADDR_WIDTH-1:0] SIZE_A = ADDR_WIDTH'(L2_SIZE);

   logic                    any_gnt;
   logic                    in_win;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [ADDR_WIDTH-1:0]   offset;
   logic                    sel_we;
   logic [DATA_WIDTH/8-1:0] sel_be;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic [DATA_WIDTH-1:0]   rsp_rdata;
   rsp_t                    rsp_q, rsp_d;

   l2_rr_arb2 #(.MAX_BURST(MAX_BURST)) u_rr (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .soc_req_i (soc_req_i),
      .dbg_req_i (dbg_req_i),
      .soc_gnt_o (soc_gnt_o),
      .dbg_gnt_o (dbg_gnt_o)
   );

   // An address below the base wraps to a huge offset, so one unsigned compare
   // covers both window bounds.
   always_comb begin
      any_gnt   = dbg_gnt_o | soc_gnt_o;
      sel_addr  = dbg_gnt_o ? dbg_addr_i  : soc_addr_i;
      sel_we    = dbg_gnt_o ? dbg_we_i    : soc_we_i;
      sel_be    = dbg_gnt_o ? dbg_be_i    : soc_be_i;
      sel_wdata = dbg_gnt_o ? dbg_wdata_i : soc_wdata_i;
      offset    = sel_addr - BASE_A;
      in_win    = (offset < SIZE_A);

      mem_req_o   = any_gnt && in_win;
      mem_we_o    = mem_req_o && sel_we;
      mem_addr_o  = mem_req_o ? (ADDR_WIDTH-2)'(offset >> 2) : '0;
      mem_be_o    = mem_req_o ? sel_be    : '0;
      mem_wdata_o = mem_req_o ? sel_wdata : '0;

      rsp_d       = '0;
      rsp_d.valid = any_gnt;
      rsp_d.id    = dbg_gnt_o ? MST_DBG : MST_SOC;
      rsp_d.err   = any_gnt && !in_win;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rsp_q <= '0;
      end else begin
         rsp_q <= rsp_d;
      end
   end

   always_comb begin
      rsp_rdata    = rsp_q.err ? ERR_DATA : mem_rdata_i;
      dbg_rvalid_o = rsp_q.valid && (rsp_q.id == MST_DBG);
      soc_rvalid_o = rsp_q.valid && (rsp_q.id == MST_SOC);
      dbg_err_o    = dbg_rvalid_o && rsp_q.err;
      soc_err_o    = soc_rvalid_o && rsp_q.err;
      dbg_rdata_o  = dbg_rvalid_o ? rsp_rdata : '0;
      soc_rdata_o  = soc_rvalid_o ? rsp_rdata : '0;
   end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb/tb_l2_port_arbiter.sv - self-checking bench for l2_port_arbiter
module tb_l2_port_arbiter;

   localparam int          MB   = 4;
   localparam logic [31:0] ERRD = 32'hBADA_CCE5;

   logic        clk, rst;
   logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_err;
   logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
   logic [3:0]  dbg_be;
   logic        soc_req, soc_we, soc_gnt, soc_rvalid, soc_err;
   logic [31:0] soc_addr, soc_wdata, soc_rdata;
   logic [3:0]  soc_be;
   logic        mem_req, mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata, mem_rdata;

   int n_tests = 0;
   int n_fail  = 0;

   l2_port_arbiter #(.MAX_BURST(MB)) dut (
      .clk_i(clk), .rst_i(rst),
      .dbg_req_i(dbg_req), .dbg_addr_i(dbg_addr), .dbg_we_i(dbg_we), .dbg_be_i(dbg_be),
      .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid),
      .dbg_rdata_o(dbg_rdata), .dbg_err_o(dbg_err),
      .soc_req_i(soc_req), .soc_addr_i(soc_addr), .soc_we_i(soc_we), .soc_be_i(soc_be),
      .soc_wdata_i(soc_wdata), .soc_gnt_o(soc_gnt), .soc_rvalid_o(soc_rvalid),
      .soc_rdata_o(soc_rdata), .soc_err_o(soc_err),
      .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
      .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM with one-cycle read latency
   logic [31:0] sram [0:16383];
   logic        sram_clr;
   always @(posedge clk) begin
      if (sram_clr) begin
         for (int i = 0; i < 16384; i++) sram[i] <= '0;
      end else if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_be[b]) sram[mem_addr[13:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            mem_rdata <= sram[mem_addr[13:0]];
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drv_dbg(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
      dbg_req = req; dbg_we = we; dbg_addr = addr; dbg_be = be; dbg_wdata = wd;
   endtask

   task automatic drv_soc(input logic req, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wd);
      soc_req = req; soc_we = we; soc_addr = addr; soc_be = be; soc_wdata = wd;
   endtask

   task automatic idle();
      drv_dbg(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      drv_soc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   task automatic chk_quiet(input string name);
      chk({name, "_ctl"}, {dbg_gnt, soc_gnt, mem_req, dbg_rvalid, soc_rvalid, dbg_err, soc_err}, 64'h0);
      chk({name, "_rdata"}, {dbg_rdata, soc_rdata}, 64'h0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drv_dbg(1'b1, 1'b0, 32'h400, 4'hF, 32'h0);
      drv_soc(1'b1, 1'b0, 32'h404, 4'hF, 32'h0);
      #1 chk_quiet("reset");
      @(negedge clk);
      rst = 1'b0;
      idle();
   endtask

   typedef struct {
      logic        dr, sr;
      logic [31:0] da, sa;
      logic        edg, esg, emr;
   } vec_t;

   function automatic vec_t mk(input logic dr, input logic sr, input logic [31:0] da,
                               input logic [31:0] sa, input logic edg, input logic esg,
                               input logic emr);
      vec_t v;
      v.dr = dr; v.sr = sr; v.da = da; v.sa = sa; v.edg = edg; v.esg = esg; v.emr = emr;
      return v;
   endfunction

   typedef struct {
      logic        req, we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } txn_t;

   function automatic txn_t rnd_txn();
      txn_t t;
      t.req  = 1'b1;
      t.we   = 1'($urandom_range(0, 1));
      t.addr = ($urandom_range(0, 9) == 0) ? 32'h10000 + 32'(4 * $urandom_range(0, 15))
                                           : 32'h400 + 32'(4 * $urandom_range(0, 15));
      t.be   = 4'($urandom);
      t.wd   = $urandom;
      return t;
   endfunction

   vec_t        tbl [18];
   logic        prev_dg, prev_sg;
   txn_t        pd, ps, t;
   logic [31:0] shadow [16];
   logic        m_owner_dbg, m_live, win_dbg, any, t_in;
   int          m_cnt;
   logic        ex_valid, ex_dbg, ex_err, ex_read;
   logic [31:0] ex_data;
   int          idx;

   initial begin
      rst = 1'b1;
      sram_clr = 1'b1;
      mem_rdata = '0;
      idle();
      repeat (2) @(negedge clk);
      sram_clr = 1'b0;
      do_reset();

      // debug write then read back
      @(negedge clk); drv_dbg(1'b1, 1'b1, 32'h0, 4'hF, 32'hABBA_ABBA);
      #1 chk("t1_wr_gnt", {dbg_gnt, soc_gnt, mem_req, mem_we}, 4'b1011);
      chk("t1_wr_addr", mem_addr, 0);
      @(negedge clk); drv_dbg(1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
      #1 chk("t1_wr_rsp", {dbg_rvalid, dbg_err, soc_rvalid}, 3'b100);
      chk("t1_rd_gnt", {dbg_gnt, mem_req, mem_we}, 3'b110);
      @(negedge clk); idle();
      #1 chk("t1_rd_rsp", {dbg_rvalid, dbg_err}, 2'b10);
      chk("t1_rd_data", dbg_rdata, 32'hABBA_ABBA);

      // partial-byte soc write, debug read
      @(negedge clk); drv_soc(1'b1, 1'b1, 32'h10, 4'b0011, 32'h1234_5678);
      #1 chk("t6_wr", {soc_gnt, mem_req, mem_be, mem_addr}, {2'b11, 4'b0011, 30'h4});
      @(negedge clk); idle(); drv_dbg(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
      #1 chk("t6_rsp", {soc_rvalid, dbg_gnt}, 2'b11);
      @(negedge clk); idle();
      #1 chk("t6_data", {dbg_rvalid, dbg_rdata}, {1'b1, 32'h0000_5678});

      // out-of-window accesses
      @(negedge clk); drv_dbg(1'b1, 1'b0, 32'h10000, 4'hF, 32'h0);
      #1 chk("t4_gnt", {dbg_gnt, mem_req}, 2'b10);
      @(negedge clk); drv_dbg(1'b1, 1'b1, 32'h1FFFC, 4'hF, 32'hDEAD_BEEF);
      #1 chk("t4_err", {dbg_rvalid, dbg_err, dbg_rdata}, {2'b11, ERRD});
      chk("t4_wr_gnt", {dbg_gnt, mem_req}, 2'b10);
      @(negedge clk); drv_dbg(1'b1, 1'b0, 32'hFFFC, 4'hF, 32'h0);
      #1 chk("t4_wr_err", {dbg_rvalid, dbg_err}, 2'b11);
      chk("t4_edge_addr", {mem_req, mem_addr}, {1'b1, 30'h3FFF});
      @(negedge clk); idle();
      #1 chk("t4_edge_data", {dbg_rvalid, dbg_err, dbg_rdata}, {2'b10, 32'h0});

      // arbitration pattern table from a fresh reset
      for (int i = 0; i < 4; i++) tbl[i] = mk(1'b1, 1'b1, 32'h400, 32'h404, 1'b1, 1'b0, 1'b1);
      for (int i = 4; i < 8; i++) tbl[i] = mk(1'b1, 1'b1, 32'h400, 32'h404, 1'b0, 1'b1, 1'b1);
      tbl[8]  = mk(1'b1, 1'b1, 32'h400, 32'h404, 1'b1, 1'b0, 1'b1);
      tbl[9]  = mk(1'b1, 1'b1, 32'h400, 32'h404, 1'b1, 1'b0, 1'b1);
      tbl[10] = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0);
      tbl[11] = mk(1'b0, 1'b1, 32'h0,   32'h408, 1'b0, 1'b1, 1'b1);
      tbl[12] = mk(1'b1, 1'b0, 32'h40C, 32'h0,   1'b1, 1'b0, 1'b1);
      tbl[13] = mk(1'b0, 1'b1, 32'h0,   32'h408, 1'b0, 1'b1, 1'b1);
      tbl[14] = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0);
      tbl[15] = mk(1'b1, 1'b1, 32'h400, 32'h404, 1'b0, 1'b1, 1'b1);
      tbl[16] = mk(1'b1, 1'b0, 32'h10000, 32'h0, 1'b1, 1'b0, 1'b0);
      tbl[17] = mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0, 1'b0);
      do_reset();
      prev_dg = 1'b0; prev_sg = 1'b0;
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drv_dbg(tbl[i].dr, 1'b0, tbl[i].da, 4'hF, 32'h0);
         drv_soc(tbl[i].sr, 1'b0, tbl[i].sa, 4'hF, 32'h0);
         #1 chk($sformatf("tbl%0d_gnt", i), {dbg_gnt, soc_gnt, mem_req},
                {tbl[i].edg, tbl[i].esg, tbl[i].emr});
         chk($sformatf("tbl%0d_rvalid", i), {dbg_rvalid, soc_rvalid}, {prev_dg, prev_sg});
         prev_dg = tbl[i].edg; prev_sg = tbl[i].esg;
      end

      // reset while a soc response is pending
      @(negedge clk); idle(); drv_soc(1'b1, 1'b0, 32'h400, 4'hF, 32'h0);
      #1 chk("t5_gnt", soc_gnt, 1);
      @(posedge clk); #1 rst = 1'b1;
      #1 chk_quiet("t5_in_reset");
      @(negedge clk); rst = 1'b0; idle();
      #1 chk("t5_no_rvalid0", {soc_rvalid, dbg_rvalid}, 0);
      @(negedge clk);
      #1 chk("t5_no_rvalid1", {soc_rvalid, dbg_rvalid}, 0);
      @(negedge clk);
      drv_dbg(1'b1, 1'b0, 32'h400, 4'hF, 32'h0);
      drv_soc(1'b1, 1'b0, 32'h404, 4'hF, 32'h0);
      #1 chk("t5_first_gnt", {dbg_gnt, soc_gnt}, 2'b10);

      // randomized traffic against a rule-level model
      do_reset();
      for (int i = 0; i < 16; i++) shadow[i] = '0;
      m_owner_dbg = 1'b0; m_cnt = 0; m_live = 1'b0;
      ex_valid = 1'b0; ex_dbg = 1'b0; ex_err = 1'b0; ex_read = 1'b0; ex_data = '0;
      pd = '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0};
      ps = pd;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!pd.req && $urandom_range(0, 9) < 6) pd = rnd_txn();
         if (!ps.req && $urandom_range(0, 9) < 6) ps = rnd_txn();
         @(negedge clk);
         drv_dbg(pd.req, pd.we, pd.addr, pd.be, pd.wd);
         drv_soc(ps.req, ps.we, ps.addr, ps.be, ps.wd);
         #1;
         any = pd.req | ps.req;
         if (pd.req && ps.req) win_dbg = (m_live && m_cnt < MB - 1) ? m_owner_dbg : !m_owner_dbg;
         else                  win_dbg = pd.req;
         chk("rnd_gnt", {dbg_gnt, soc_gnt}, {any && win_dbg, any && !win_dbg});

         chk("rnd_rvalid", {dbg_rvalid, soc_rvalid, dbg_err, soc_err},
             {ex_valid && ex_dbg, ex_valid && !ex_dbg,
              ex_valid && ex_dbg && ex_err, ex_valid && !ex_dbg && ex_err});
         if (!ex_valid) chk("rnd_idle_rdata", {dbg_rdata, soc_rdata}, 0);
         else if (ex_dbg) chk("rnd_other_rdata", soc_rdata, 0);
         else chk("rnd_other_rdata", dbg_rdata, 0);
         if (ex_valid && (ex_err || ex_read))
            chk("rnd_rdata", ex_dbg ? dbg_rdata : soc_rdata, ex_data);

         t    = win_dbg ? pd : ps;
         t_in = t.addr < 32'h10000;
         if (any && t_in)
            chk("rnd_mem", {mem_req, mem_we, mem_addr, mem_be, mem_wdata},
                {1'b1, t.we, 30'(t.addr >> 2), t.be, t.wd});
         else
            chk("rnd_mem_req", mem_req, 0);

         ex_valid = any; ex_dbg = win_dbg; ex_err = !t_in; ex_read = !t.we;
         idx = int'((t.addr - 32'h400) >> 2);
         ex_data = ERRD;
         if (t_in) begin
            ex_data = shadow[idx];
            if (any && t.we)
               for (int b = 0; b < 4; b++)
                  if (t.be[b]) shadow[idx][8*b +: 8] = t.wd[8*b +: 8];
         end

         if (any) begin
            if (win_dbg == m_owner_dbg) m_cnt = (m_cnt < MB - 1) ? m_cnt + 1 : m_cnt;
            else begin m_owner_dbg = win_dbg; m_cnt = 0; end
            m_live = 1'b1;
            if (win_dbg) pd.req = 1'b0; else ps.req = 1'b0;
         end else begin
            m_cnt = 0;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/l2_port_arbiter.md
Name: l2_port_arbiter

Overview:
Two-master arbiter in front of the single-port L2 SRAM. It shares the SRAM between the JTAG debug bus master (pulp TAP read32/write32 path) and the SoC-side master. It uses the TCDM-style req/gnt/rvalid protocol on both masters with a 1-cycle SRAM read latency. It adds round-robin fairness with a bounded burst hold and out-of-window error responses, so debug R/W of L2 works while the SoC is active.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
DATA_WIDTH, 32, data width; BE width = DATA_WIDTH/8
L2_BASE, 32'h0000_0000, first byte address of the L2 window
L2_SIZE, 32'h0001_0000, window size in bytes (power of two)
MAX_BURST, 4, max consecutive grants to one master while the other waits (>=1)
ERR_DATA, 32'hBADACCE5, rdata returned on error responses

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
dbg_req_i  in  1  debug master request
dbg_addr_i  in  ADDR_WIDTH  byte address
dbg_we_i  in  1  1=write
dbg_be_i  in  DATA_WIDTH/8  byte enables
dbg_wdata_i  in  DATA_WIDTH  write data
dbg_gnt_o  out  1  grant (combinational, same cycle)
dbg_rvalid_o  out  1  response valid, 1 cycle after gnt
dbg_rdata_o  out  DATA_WIDTH  read data
dbg_err_o  out  1  error, qualified by rvalid
soc_*  same seven signals as dbg_*, for the SoC master
mem_req_o  out  1  SRAM chip select
mem_we_o  out  1  SRAM write enable
mem_addr_o  out  ADDR_WIDTH-2  word address, (addr-L2_BASE)>>2
mem_be_o  out  DATA_WIDTH/8  byte enables
mem_wdata_o  out  DATA_WIDTH  write data
mem_rdata_i  in  DATA_WIDTH  SRAM read data, valid 1 cycle after mem_req_o

Behaviour:
- Reset (rst_i=1, async): all *_gnt/*_rvalid/*_err and mem_req_o = 0; owner_q = SOC; burst_cnt_q = 0; rsp pipeline cleared.
- In reset, rdata outputs are 0 and gnt is forced 0 regardless of req.
- Arbitration (combinational on req, registered state owner_q = last granted master, burst_cnt_q):
  - Only one req: grant it.
  - Both req and owner_q requesting with burst_cnt_q < MAX_BURST-1: grant owner_q (burst hold).
  - Both req otherwise: grant the master != owner_q.
  - No req: no grant; burst_cnt_q <= 0; owner_q holds.
- State update on a grant:
  - Same master as owner_q: burst_cnt_q++ (saturating at MAX_BURST-1).
  - Else: owner_q <= granted master; burst_cnt_q <= 0.
- Exactly one gnt per cycle at most. A master with req=1 and gnt=0 holds its request stable; the arbiter does not require this but the bench checks it.
- Address check: in-window iff L2_BASE <= addr < L2_BASE+L2_SIZE.
  - Granted in-window request: mem_req_o=1, mem_* driven from the winner.
  - Granted out-of-window request: gnt=1 but mem_req_o=0; response is err=1, rdata=ERR_DATA; writes are dropped.
- Response stage: registers rsp_valid_q, rsp_id_q, rsp_err_q.
  - The cycle after a grant, rvalid=1 for that master (reads and writes alike).
  - rdata = mem_rdata_i, or ERR_DATA when err=1.
  - The non-addressed master sees rvalid=0 and rdata=0.
- Back-to-back: a new grant is allowed every cycle; the response for cycle N appears in cycle N+1, concurrent with grant N+1. Throughput is 1 access/cycle.
- Latency: req->gnt 0 cycles; gnt->rvalid 1 cycle.
- Reset mid-operation: a pending response is discarded (no rvalid after reset release); the first grant after release follows the owner_q=SOC rule.
- mem_* data/address outputs are don't-care when mem_req_o=0; drive them to 0.

Decomposition:
- Package l2_arb_pkg: master id enum {MST_SOC=0, MST_DBG=1}, ERR_DATA default, response struct {valid, id, err}.
- Sub-module l2_rr_arb2 holds the 2-way round-robin/burst-hold grant logic with owner_q/burst_cnt_q.
- Top l2_port_arbiter holds the address decode, request mux and response stage.

Test Plan:
1. Debug write32 0xABBAABBA to 0x0000_0000, be=4'hF, soc idle -> dbg_gnt same cycle, mem_addr_o=0, dbg_rvalid next cycle, err=0. Read back -> dbg_rdata_o=0xABBAABBA.
2. Both req every cycle from reset, MAX_BURST=4 -> grant pattern DBG,DBG,DBG,DBG,SOC,SOC,SOC,SOC,DBG,... Each rvalid is routed to the correct master one cycle later.
3. Alternating single requests with no contention -> no stall, one access per cycle. burst_cnt_q returns to 0 after an idle cycle.
4. dbg read at 0x0001_0000 (just past window) -> gnt=1, mem_req_o=0, next cycle dbg_rvalid=1, dbg_err=1, rdata=0xBADACCE5. SRAM contents unchanged, checked by re-reading 0xFFFC.
5. Assert rst_i for 1 cycle during the rvalid-pending cycle after a soc read -> no soc_rvalid after release; all outputs 0 during reset.
6. soc writes 0x1234_5678 with be=4'b0011 at 0x10, then dbg reads 0x10 -> dbg_rdata_o=0x0000_5678 (SRAM pre-cleared).
